// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and control bundle.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StImiss = 2'd1,
        StKill  = 2'd2,
        StHalt  = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_sel_redir;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic halted;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-source inputs and pipeline-control outputs of the hazard controller.
// HAZARD_PERF_EN adds the four performance-counter outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 3
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned PERF_W     = 16
`endif
);
    logic                  idex_memread;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic [REG_ADDR_W-1:0] ifid_rs;
    logic [REG_ADDR_W-1:0] ifid_rt;
    logic                  ifid_use_rs;
    logic                  ifid_use_rt;
    logic                  ex_redirect;
    logic                  imem_stall;
    logic                  dmem_stall;
    logic                  wb_halt;

    logic                  pc_en;
    logic                  pc_sel_redir;
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic                  idex_stall;
    logic                  idex_flush;
    logic                  exmem_stall;
    logic                  halted;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0]     perf_lu;
    logic [PERF_W-1:0]     perf_redir;
    logic [PERF_W-1:0]     perf_imiss;
    logic [PERF_W-1:0]     perf_dmem;
`endif

    // Core side: drives hazard sources, consumes pipeline controls.
    modport master (
        output idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt,
        output ex_redirect, imem_stall, dmem_stall, wb_halt,
`ifdef HAZARD_PERF_EN
        input  perf_lu, perf_redir, perf_imiss, perf_dmem,
`endif
        input  pc_en, pc_sel_redir, ifid_stall, ifid_flush,
        input  idex_stall, idex_flush, exmem_stall, halted
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt,
        input  ex_redirect, imem_stall, dmem_stall, wb_halt,
`ifdef HAZARD_PERF_EN
        output perf_lu, perf_redir, perf_imiss, perf_dmem,
`endif
        output pc_en, pc_sel_redir, ifid_stall, ifid_flush,
        output idex_stall, idex_flush, exmem_stall, halted
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: flags an ID instruction reading the destination of a load sitting in EX.
module pipeline_hazard_ctrl_load_use_detect #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  ifid_use_rs_i,
    input  logic                  ifid_use_rt_i,
    output logic                  lu_o
);

    assign lu_o = idex_memread_i &
                  ((ifid_use_rs_i & (ifid_rs_i == idex_rd_i)) |
                   (ifid_use_rt_i & (ifid_rt_i == idex_rd_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush/PC-enable from hazard priority and fetch FSM.
// Optional HAZARD_PERF_EN adds saturating per-hazard cycle counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz_if
);

    hz_state_e state_q, state_d;
    hz_ctrl_t  ctrl;
    logic      lu;
    logic      own_halt, own_dmem, own_redir, own_lu, own_imiss;

    pipeline_hazard_ctrl_load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu (
        .idex_memread_i (hz_if.idex_memread),
        .idex_rd_i      (hz_if.idex_rd),
        .ifid_rs_i      (hz_if.ifid_rs),
        .ifid_rt_i      (hz_if.ifid_rt),
        .ifid_use_rs_i  (hz_if.ifid_use_rs),
        .ifid_use_rt_i  (hz_if.ifid_use_rt),
        .lu_o           (lu)
    );

    // Which hazard owns the pipeline this cycle, in strict priority order.
    assign own_halt  = (state_q == StHalt);
    assign own_dmem  = !own_halt && hz_if.dmem_stall;
    assign own_redir = !own_halt && !hz_if.dmem_stall && hz_if.ex_redirect;
    assign own_lu    = !own_halt && !hz_if.dmem_stall && !hz_if.ex_redirect && lu;
    assign own_imiss = !own_halt && !hz_if.dmem_stall && !hz_if.ex_redirect && !lu &&
                       hz_if.imem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun, StImiss, StKill: begin
                if (hz_if.wb_halt && !hz_if.dmem_stall) begin
                    state_d = StHalt;
                end else if (hz_if.dmem_stall) begin
                    state_d = state_q;
                end else if (hz_if.ex_redirect) begin
                    state_d = hz_if.imem_stall ? StKill : StRun;
                end else if (hz_if.imem_stall) begin
                    // An outstanding wrong-path fetch stays wrong-path until it returns.
                    state_d = (state_q == StKill) ? StKill : StImiss;
                end else begin
                    state_d = StRun;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (own_halt) begin
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
            ctrl.halted      = 1'b1;
        end else if (own_dmem) begin
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
        end else if (own_redir) begin
            ctrl.pc_en        = 1'b1;
            ctrl.pc_sel_redir = 1'b1;
            ctrl.ifid_flush   = 1'b1;
            ctrl.idex_flush   = 1'b1;
        end else if (own_lu) begin
            ctrl.ifid_stall = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (own_imiss || (state_q == StKill)) begin
            // The returning wrong-path word is also dropped; PC already holds the target.
            ctrl.ifid_flush = 1'b1;
        end else begin
            ctrl.pc_en = 1'b1;
        end
    end

    assign hz_if.pc_en        = ctrl.pc_en;
    assign hz_if.pc_sel_redir = ctrl.pc_sel_redir;
    assign hz_if.ifid_stall   = ctrl.ifid_stall;
    assign hz_if.ifid_flush   = ctrl.ifid_flush;
    assign hz_if.idex_stall   = ctrl.idex_stall;
    assign hz_if.idex_flush   = ctrl.idex_flush;
    assign hz_if.exmem_stall  = ctrl.exmem_stall;
    assign hz_if.halted       = ctrl.halted;

`ifdef HAZARD_PERF_EN
    localparam int unsigned PerfW = $bits(hz_if.perf_lu);

    logic [PerfW-1:0] perf_q [4];
    logic [PerfW-1:0] perf_d [4];
    logic [3:0]       perf_hit;

    assign perf_hit = {own_dmem, own_imiss, own_redir, own_lu};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            perf_d[i] = perf_q[i];
            if (perf_hit[i] && (perf_q[i] != '1)) begin
                perf_d[i] = perf_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                perf_q[i] <= perf_d[i];
            end
        end
    end

    assign hz_if.perf_lu    = perf_q[0];
    assign hz_if.perf_redir = perf_q[1];
    assign hz_if.perf_imiss = perf_q[2];
    assign hz_if.perf_dmem  = perf_q[3];
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised self-checking bench for pipeline_hazard_ctrl against a wrong-path/halted reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RegAddrW = 3;

    // Control vector bit order: pc_en, pc_sel_redir, ifid_stall, ifid_flush,
    // idex_stall, idex_flush, exmem_stall, halted.
    localparam logic [7:0] VecReset = 8'b0001_0100;
    localparam logic [7:0] VecHalt  = 8'b0010_1011;
    localparam logic [7:0] VecDmem  = 8'b0010_1010;
    localparam logic [7:0] VecRedir = 8'b1101_0100;
    localparam logic [7:0] VecLu    = 8'b0010_0100;
    localparam logic [7:0] VecFlush = 8'b0001_0000;
    localparam logic [7:0] VecRun   = 8'b1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(RegAddrW)) hz_if ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RegAddrW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (hz_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: is the outstanding fetch wrong-path, and has the core halted.
    bit m_halted;
    bit m_wrong_path;
`ifdef HAZARD_PERF_EN
    localparam int unsigned PerfW = $bits(hz_if.perf_lu);
    longint unsigned m_perf [4];
    longint unsigned perf_max = (64'd1 << PerfW) - 1;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {hz_if.pc_en, hz_if.pc_sel_redir, hz_if.ifid_stall, hz_if.ifid_flush,
                hz_if.idex_stall, hz_if.idex_flush, hz_if.exmem_stall, hz_if.halted};
    endfunction

    function automatic bit model_lu();
        return hz_if.idex_memread &&
               ((hz_if.ifid_use_rs && hz_if.ifid_rs == hz_if.idex_rd) ||
                (hz_if.ifid_use_rt && hz_if.ifid_rt == hz_if.idex_rd));
    endfunction

    function automatic logic [7:0] model_vec();
        if (m_halted)               return VecHalt;
        if (hz_if.dmem_stall)       return VecDmem;
        if (hz_if.ex_redirect)      return VecRedir;
        if (model_lu())             return VecLu;
        if (m_wrong_path)           return VecFlush;
        if (hz_if.imem_stall)       return VecFlush;
        return VecRun;
    endfunction

    task automatic drive(input bit memread, input int rd, input int rs, input int rt,
                         input bit urs, input bit urt, input bit redir, input bit imem,
                         input bit dmem, input bit halt);
        hz_if.idex_memread = memread;
        hz_if.idex_rd      = RegAddrW'(rd);
        hz_if.ifid_rs      = RegAddrW'(rs);
        hz_if.ifid_rt      = RegAddrW'(rt);
        hz_if.ifid_use_rs  = urs;
        hz_if.ifid_use_rt  = urt;
        hz_if.ex_redirect  = redir;
        hz_if.imem_stall   = imem;
        hz_if.dmem_stall   = dmem;
        hz_if.wb_halt      = halt;
    endtask

    task automatic idle(input bit imem);
        drive(0, 0, 1, 2, 0, 0, 0, imem, 0, 0);
    endtask

    // Check the current cycle at the falling edge, then advance the model at the rising edge.
    task automatic step(output logic [7:0] seen);
        bit lu;
        @(negedge clk);
        seen = dut_vec();
        check_eq("ctrl", {24'd0, seen}, {24'd0, model_vec()});
        check_eq("ifid_stall_flush", {31'd0, hz_if.ifid_stall & hz_if.ifid_flush}, 32'd0);
        check_eq("idex_stall_flush", {31'd0, hz_if.idex_stall & hz_if.idex_flush}, 32'd0);
`ifdef HAZARD_PERF_EN
        check_eq("perf_lu",    32'(hz_if.perf_lu),    32'(m_perf[0]));
        check_eq("perf_redir", 32'(hz_if.perf_redir), 32'(m_perf[1]));
        check_eq("perf_imiss", 32'(hz_if.perf_imiss), 32'(m_perf[2]));
        check_eq("perf_dmem",  32'(hz_if.perf_dmem),  32'(m_perf[3]));
`endif
        lu = model_lu();
        @(posedge clk);
        if (!m_halted) begin
`ifdef HAZARD_PERF_EN
            begin
                int idx;
                idx = hz_if.dmem_stall ? 3 : hz_if.ex_redirect ? 1 : lu ? 0 :
                      hz_if.imem_stall ? 2 : -1;
                if (idx >= 0 && m_perf[idx] < perf_max) m_perf[idx]++;
            end
`endif
            if (hz_if.wb_halt && !hz_if.dmem_stall) begin
                m_halted = 1'b1;
            end else if (!hz_if.dmem_stall) begin
                if (hz_if.ex_redirect) m_wrong_path = hz_if.imem_stall;
                else                   m_wrong_path = m_wrong_path && hz_if.imem_stall;
            end
        end
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        idle(0);
        #2;
        check_eq("rst_ctrl", {24'd0, dut_vec()}, {24'd0, VecReset});
        m_halted     = 1'b0;
        m_wrong_path = 1'b0;
`ifdef HAZARD_PERF_EN
        for (int i = 0; i < 4; i++) m_perf[i] = 0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] seen;
    int         flush_cnt;
    int         halt_cycles;

    initial begin
        idle(0);
        #3;
        do_reset();

        // Load r3 in EX, ID reads r3 as rt: one bubble, then normal flow.
        drive(1, 3, 1, 3, 1, 1, 0, 0, 0, 0);
        step(seen);
        check_eq("t1_lu", {24'd0, seen}, {24'd0, VecLu});
        drive(0, 3, 1, 3, 1, 1, 0, 0, 0, 0);
        step(seen);
        check_eq("t1_after", {24'd0, seen}, {24'd0, VecRun});

        // Redirect with fetch ready: one flush cycle then run.
        drive(0, 0, 1, 2, 0, 0, 1, 0, 0, 0);
        step(seen);
        check_eq("t2_redir", {24'd0, seen}, {24'd0, VecRedir});
        idle(0);
        step(seen);
        check_eq("t2_after", {24'd0, seen}, {24'd0, VecRun});

        // Redirect during a pending fetch: flush through the wrong-path return.
        flush_cnt = 0;
        drive(0, 0, 1, 2, 0, 0, 1, 1, 0, 0);
        step(seen);
        flush_cnt += int'(seen[4]);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            step(seen);
            flush_cnt += int'(seen[4]);
            check_eq("t3_kill_pc", {31'd0, seen[7]}, 32'd0);
        end
        idle(0);
        step(seen);
        flush_cnt += int'(seen[4]);
        check_eq("t3_return", {24'd0, seen}, {24'd0, VecFlush});
        check_eq("t3_flush_cycles", flush_cnt, 4);
        idle(0);
        step(seen);
        check_eq("t3_run", {24'd0, seen}, {24'd0, VecRun});

        // Data stall with redirect and load-use pending: full freeze, then redirect.
        for (int i = 0; i < 2; i++) begin
            drive(1, 5, 5, 0, 1, 0, 1, 0, 1, 0);
            step(seen);
            check_eq("t4_freeze", {24'd0, seen}, {24'd0, VecDmem});
        end
        drive(1, 5, 5, 0, 1, 0, 1, 0, 0, 0);
        step(seen);
        check_eq("t4_release", {24'd0, seen}, {24'd0, VecRedir});

        // HALT is sticky regardless of inputs, cleared only by reset.
        drive(0, 0, 1, 2, 0, 0, 0, 0, 0, 1);
        step(seen);
        for (int i = 0; i < 6; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
            step(seen);
            check_eq("t5_halted", {24'd0, seen}, {24'd0, VecHalt});
        end
        do_reset();

`ifdef HAZARD_PERF_EN
        for (int i = 0; i < 5; i++) begin
            idle(1);
            step(seen);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 2, 2, 0, 1, 0, 0, 0, 0, 0);
            step(seen);
            idle(0);
            step(seen);
        end
        check_eq("t6_imiss", 32'(hz_if.perf_imiss), 32'd5);
        check_eq("t6_lu", 32'(hz_if.perf_lu), 32'd2);
        for (int i = 0; i < (1 << PerfW) + 3; i++) begin
            drive(0, 0, 1, 2, 0, 0, 0, 0, 1, 0);
            step(seen);
        end
        idle(0);
        step(seen);
        check_eq("t6_dmem_sat", 32'(hz_if.perf_dmem), 32'(perf_max));
        do_reset();
`endif

        // Randomised traffic with occasional halts.
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
            step(seen);
            if (m_halted) halt_cycles++;
            if (halt_cycles > 8) begin
                halt_cycles = 0;
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
